// File: rtl/ip_ram_pkg.sv
// Shared constants for the arbitrated bus RAM: read-latency limits, FSM states, channel ids.
package ip_ram_pkg;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/ip_ram_rd_pipe.sv
// Read-return delay line carrying {en, channel, data}; only the en bits are cleared by reset.
module ip_ram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_en,
    input  logic              in_ch,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_en,
    output logic              out_ch,
    output logic [DATA_W-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_wire
            assign out_en   = in_en;
            assign out_ch   = in_ch;
            assign out_data = in_data;
        end else begin : g_regs
            logic [STAGES-1:0] vld_pn;
            logic [STAGES-1:0] ch_pn;
            logic [DATA_W-1:0] data_pn [STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_pn <= '0;
                end else begin
                    vld_pn[0] <= in_en;
                    for (int i = 1; i < STAGES; i++) vld_pn[i] <= vld_pn[i-1];
                end
            end

            // Tag and data need no reset: they are only observed alongside a set en bit.
            always_ff @(posedge clk) begin
                ch_pn[0]   <= in_ch;
                data_pn[0] <= in_data;
                for (int i = 1; i < STAGES; i++) begin
                    ch_pn[i]   <= ch_pn[i-1];
                    data_pn[i] <= data_pn[i-1];
                end
            end

            assign out_en   = vld_pn[STAGES-1];
            assign out_ch   = ch_pn[STAGES-1];
            assign out_data = data_pn[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ip_ram_arb.sv
// Single-port RAM shared by two bus channels through a round-robin arbiter, configurable read latency.
// Optional build macro IP_RAM_CLEAR_EN: zero the whole array after every reset release.
module ip_ram_arb
    import ip_ram_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] bus0_address,
    input  logic              bus0_valid,
    output logic              bus0_ready,
    input  logic              bus0_write,
    input  logic [DATA_W-1:0] bus0_wdata,
    output logic [DATA_W-1:0] bus0_rdata,
    output logic              bus0_rdata_en,
    input  logic [ADDR_W-1:0] bus1_address,
    input  logic              bus1_valid,
    output logic              bus1_ready,
    input  logic              bus1_write,
    input  logic [DATA_W-1:0] bus1_wdata,
    output logic [DATA_W-1:0] bus1_rdata,
    output logic              bus1_rdata_en
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_latency
            $error("ip_ram_arb: READ_LATENCY must be within 1..8");
        end
    endgenerate

`ifdef IP_RAM_CLEAR_EN
    localparam state_t ST_INIT = ST_CLEAR;
    logic [ADDR_W-1:0] clr_addr;
`else
    localparam state_t ST_INIT = ST_RUN;
`endif

    state_t            state;
    state_t            state_nx;
    logic              ff_prio;
    logic              grant0;
    logic              grant1;
    logic              acc_ch;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_write;
    logic [DATA_W-1:0] acc_wdata;
    logic              wr;
    logic              rd;
    logic              vld_p0;
    logic              ch_p0;
    logic [DATA_W-1:0] data_p0;
    logic              vld_out;
    logic              ch_out;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
`ifdef IP_RAM_CLEAR_EN
        if (state == ST_CLEAR && (&clr_addr)) state_nx = ST_RUN;
`endif
    end

    // Grants are combinational; on contention ff_prio names the winner.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_RUN) begin
            grant0 = bus0_valid && (!bus1_valid || ff_prio == CH0);
            grant1 = bus1_valid && (!bus0_valid || ff_prio == CH1);
        end
    end

    assign bus0_ready = grant0;
    assign bus1_ready = grant1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                    ff_prio <= CH0;
        else if ((grant0 || grant1) && bus0_valid && bus1_valid) ff_prio <= ~ff_prio;
    end

`ifdef IP_RAM_CLEAR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               clr_addr <= '0;
        else if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
    end
`endif

    always_comb begin
        acc_ch    = grant1 ? CH1 : CH0;
        acc_addr  = grant1 ? bus1_address : bus0_address;
        acc_write = grant1 ? bus1_write : bus0_write;
        acc_wdata = grant1 ? bus1_wdata : bus0_wdata;
        wr        = (grant0 || grant1) && acc_write;
        rd        = (grant0 || grant1) && !acc_write;
    end

    // Stage 1: array access at the accepting edge
    always_ff @(posedge clk) begin
`ifdef IP_RAM_CLEAR_EN
        if (state == ST_CLEAR) mem[clr_addr] <= '0;
        else
`endif
        if (wr) mem[acc_addr] <= acc_wdata;
        if (rd) begin
            data_p0 <= mem[acc_addr];
            ch_p0   <= acc_ch;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_p0 <= 1'b0;
        else          vld_p0 <= rd;
    end

    // Stages 2..READ_LATENCY
    ip_ram_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_en    (vld_p0),
        .in_ch    (ch_p0),
        .in_data  (data_p0),
        .out_en   (vld_out),
        .out_ch   (ch_out),
        .out_data (data_out)
    );

    assign bus0_rdata_en = vld_out && (ch_out == CH0);
    assign bus1_rdata_en = vld_out && (ch_out == CH1);
    assign bus0_rdata    = bus0_rdata_en ? data_out : '0;
    assign bus1_rdata    = bus1_rdata_en ? data_out : '0;

endmodule
